// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone SDRAM arbiter.
// The state encoding doubles as the one-hot grant vector.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_t;

    localparam logic [1:0] GNT_IDLE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int DEF_MAX_HOLD = 16;
    localparam int DEF_TIMEOUT  = 255;
    localparam int HOLD_W       = 5;
    localparam int TO_W         = 8;

endpackage

// File: rtl/wb_timeout_mon.sv
// Counts stalled strobe cycles (stb without ack) and flags the last one
// before the bus is considered hung.
module wb_timeout_mon
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stb,
    input  logic ack,
    input  logic clr,
    output logic expired
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt_q;
    logic [TO_W-1:0] to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (clr || ack) begin
            to_cnt_d = '0;
        end else if (stb && (to_cnt_q != TO_LAST)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    // An ack arriving on the final cycle suppresses the timeout.
    assign expired = stb && !ack && (to_cnt_q == TO_LAST);

endmodule

// File: rtl/wb_sdr_arbiter.sv
// Two-master Wishbone arbiter in front of the SDRAM bridge: screen DMA (m0)
// has priority, the processor (m1) is protected from starvation.
module wb_sdr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW       = 24,
    parameter int DW       = 32,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m0_cyc,
    input  logic            m0_stb,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW/8-1:0] m0_sel,
    input  logic [DW-1:0]   m0_dat_w,
    output logic [DW-1:0]   m0_dat_r,
    output logic            m0_ack,
    output logic            m0_err,
    input  logic            m1_cyc,
    input  logic            m1_stb,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW/8-1:0] m1_sel,
    input  logic [DW-1:0]   m1_dat_w,
    output logic [DW-1:0]   m1_dat_r,
    output logic            m1_ack,
    output logic            m1_err,
    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW/8-1:0] s_sel,
    output logic [DW-1:0]   s_dat_w,
    input  logic [DW-1:0]   s_dat_r,
    input  logic            s_ack,
    output logic [1:0]      grant,
    output logic            timeout_evt
);

    arb_state_t        state_q, state_d;
    logic              fair_q, fair_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
    logic              own0, own1, expired, preempt, to_clr;

    assign own0  = (state_q == ST_OWN0);
    assign own1  = (state_q == ST_OWN1);
    assign grant = state_q;

    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_sel   = '0;
        s_dat_w = '0;
        if (own0) begin
            s_cyc   = m0_cyc;
            s_stb   = m0_stb;
            s_we    = m0_we;
            s_adr   = m0_adr;
            s_sel   = m0_sel;
            s_dat_w = m0_dat_w;
        end else if (own1) begin
            s_cyc   = m1_cyc;
            s_stb   = m1_stb;
            s_we    = m1_we;
            s_adr   = m1_adr;
            s_sel   = m1_sel;
            s_dat_w = m1_dat_w;
        end
    end

    assign m0_dat_r    = s_dat_r;
    assign m1_dat_r    = s_dat_r;
    assign m0_ack      = own0 && s_ack;
    assign m1_ack      = own1 && s_ack;
    assign m0_err      = own0 && expired;
    assign m1_err      = own1 && expired;
    assign timeout_evt = expired;

    // The ack being taken this cycle counts toward the hold limit, so m0
    // gets exactly MAX_HOLD acks before yielding at a strobe boundary.
    assign hold_inc = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + 1'b1;
    assign preempt  = own0 && s_ack && m1_cyc && (hold_inc >= HOLD_W'(MAX_HOLD));

    always_comb begin
        state_d    = state_q;
        fair_d     = fair_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (fair_q && m1_cyc) begin
                    state_d = ST_OWN1;
                    fair_d  = 1'b0;
                end else if (m0_cyc) begin
                    state_d    = ST_OWN0;
                    hold_cnt_d = '0;
                end else if (m1_cyc) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (s_ack) begin
                    hold_cnt_d = hold_inc;
                end
                if (preempt) begin
                    state_d = ST_IDLE;
                    fair_d  = 1'b1;
                end else if (!m0_cyc || expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (!m1_cyc || expired) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fair_q     <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fair_q     <= fair_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Clearing on every state change resets the stall count between owners.
    assign to_clr = (state_d != state_q);

    wb_timeout_mon #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_mon (
        .clk     (clk),
        .rst_n   (rst_n),
        .stb     (s_stb),
        .ack     (s_ack),
        .clr     (to_clr),
        .expired (expired)
    );

endmodule

// File: tb/tb_wb_sdr_arbiter.sv
// Directed bench for wb_sdr_arbiter: stimulus queues expected responses,
// a negedge monitor matches every ack/err/timeout the DUT presents.
module tb_wb_sdr_arbiter;
    import wb_arb_pkg::*;

    localparam int AW = 24;
    localparam int DW = 32;

    logic            clk, rst_n;
    logic            m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
    logic [AW-1:0]   m0_adr;
    logic [DW/8-1:0] m0_sel;
    logic [DW-1:0]   m0_dat_w, m0_dat_r;
    logic            m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
    logic [AW-1:0]   m1_adr;
    logic [DW/8-1:0] m1_sel;
    logic [DW-1:0]   m1_dat_w, m1_dat_r;
    logic            s_cyc, s_stb, s_we, s_ack;
    logic [AW-1:0]   s_adr;
    logic [DW/8-1:0] s_sel;
    logic [DW-1:0]   s_dat_w, s_dat_r;
    logic [1:0]      grant;
    logic            timeout_evt;

    wb_sdr_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_sel(m0_sel), .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_sel(m1_sel), .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_sel(s_sel), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack),
        .grant(grant), .timeout_evt(timeout_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          m0_ack;
        logic          m0_err;
        logic          m1_ack;
        logic          m1_err;
        logic          evt;
        logic [DW-1:0] dat;
    } resp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } dchk_t;

    resp_t exp_q[$];
    dchk_t dq[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        dchk_t d;
        d.name = name;
        d.act  = act;
        d.exp  = exp;
        dq.push_back(d);
    endtask

    task automatic expect_resp(input logic m0a, input logic m0e, input logic m1a,
                               input logic m1e, input logic evt);
        resp_t r;
        r.m0_ack = m0a;
        r.m0_err = m0e;
        r.m1_ack = m1a;
        r.m1_err = m1e;
        r.evt    = evt;
        r.dat    = s_dat_r;
        exp_q.push_back(r);
    endtask

    task automatic master_req(input int m, input logic [AW-1:0] adr, input logic we);
        if (m == 0) begin
            m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = we; m0_adr = adr;
            m0_sel = 4'hF; m0_dat_w = 32'h0D0D_0000 | 32'(adr);
        end else begin
            m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = we; m1_adr = adr;
            m1_sel = 4'h3; m1_dat_w = 32'h0101_0000 | 32'(adr);
        end
    endtask

    task automatic master_drop(input int m);
        if (m == 0) begin
            m0_cyc = 1'b0; m0_stb = 1'b0;
        end else begin
            m1_cyc = 1'b0; m1_stb = 1'b0;
        end
    endtask

    task automatic slave_ack(input logic [DW-1:0] dat);
        s_ack   = 1'b1;
        s_dat_r = dat;
    endtask

    // Monitor: drains direct checks and matches every response against the queue.
    always @(negedge clk) begin
        dchk_t d;
        resp_t e;
        resp_t o;
        while (dq.size() != 0) begin
            d = dq.pop_front();
            n_cmp++;
            if (d.act !== d.exp) begin
                n_bad++;
                $display("FAIL %s: got %0h, want %0h", d.name, d.act, d.exp);
            end
        end
        o.m0_ack = m0_ack;
        o.m0_err = m0_err;
        o.m1_ack = m1_ack;
        o.m1_err = m1_err;
        o.evt    = timeout_evt;
        o.dat    = (m1_ack || m1_err) ? m1_dat_r : m0_dat_r;
        if ({o.m0_ack, o.m0_err, o.m1_ack, o.m1_err, o.evt} !== 5'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_resp: got flags=%b dat=%h, want no response",
                         {o.m0_ack, o.m0_err, o.m1_ack, o.m1_err, o.evt}, o.dat);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL resp: got flags=%b dat=%h, want flags=%b dat=%h",
                             {o.m0_ack, o.m0_err, o.m1_ack, o.m1_err, o.evt}, o.dat,
                             {e.m0_ack, e.m0_err, e.m1_ack, e.m1_err, e.evt}, e.dat);
                end else begin
                    $display("resp t=%0t flags(m0a,m0e,m1a,m1e,evt)=%b dat=%h grant=%b",
                             $time, {o.m0_ack, o.m0_err, o.m1_ack, o.m1_err, o.evt}, o.dat, grant);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = '0; m0_dat_w = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_sel = '0; m1_dat_w = '0;
        s_ack = 0; s_dat_r = '0;
        tick();
        tick();
        chk("reset_grant", grant, GNT_IDLE);
        chk("reset_s_cyc", s_cyc, 0);
        chk("reset_s_stb", s_stb, 0);
        rst_n = 1'b1;
        tick();

        // Single m1 read, ack three cycles after grant.
        master_req(1, 24'h123456, 1'b0);
        chk("m1_pre_grant", grant, GNT_IDLE);
        tick();
        chk("m1_grant", grant, GNT_M1);
        chk("m1_s_adr", s_adr, 32'h123456);
        chk("m1_s_sel", s_sel, 32'h3);
        tick();
        tick();
        slave_ack(32'hCAFE_0001);
        expect_resp(0, 0, 1, 0, 0);
        tick();
        s_ack = 1'b0;
        master_drop(1);
        tick();
        chk("m1_release", grant, GNT_IDLE);

        // Simultaneous request: m0 wins, m1 waits for one IDLE cycle.
        master_req(0, 24'h000100, 1'b1);
        master_req(1, 24'h000200, 1'b0);
        tick();
        chk("simul_grant_m0", grant, GNT_M0);
        chk("simul_s_we", s_we, 1);
        chk("simul_s_dat_w", s_dat_w, 32'h0D0D_0100);
        slave_ack(32'h1111_2222);
        expect_resp(1, 0, 0, 0, 0);
        tick();
        s_ack = 1'b0;
        master_drop(0);
        chk("simul_m0_hold", grant, GNT_M0);
        tick();
        chk("simul_idle_gap", grant, GNT_IDLE);
        tick();
        chk("simul_grant_m1", grant, GNT_M1);
        slave_ack(32'h3333_4444);
        expect_resp(0, 0, 1, 0, 0);
        tick();
        s_ack = 1'b0;
        master_drop(1);
        tick();
        chk("simul_done", grant, GNT_IDLE);

        // Starvation guard: m0 bursts 40 acks while m1 waits.
        master_req(0, 24'h00A000, 1'b0);
        tick();
        chk("burst_grant_m0", grant, GNT_M0);
        master_req(1, 24'h00B000, 1'b0);
        for (int i = 0; i < 16; i++) begin
            slave_ack(32'hA000_0000 + 32'(i));
            expect_resp(1, 0, 0, 0, 0);
            tick();
        end
        s_ack = 1'b0;
        chk("burst_preempt_idle", grant, GNT_IDLE);
        tick();
        chk("burst_fair_m1", grant, GNT_M1);
        slave_ack(32'hB000_0001);
        expect_resp(0, 0, 1, 0, 0);
        tick();
        s_ack = 1'b0;
        master_drop(1);
        tick();
        chk("burst_m1_done", grant, GNT_IDLE);
        tick();
        chk("burst_m0_regrant", grant, GNT_M0);
        for (int i = 16; i < 40; i++) begin
            slave_ack(32'hA000_0000 + 32'(i));
            expect_resp(1, 0, 0, 0, 0);
            tick();
        end
        s_ack = 1'b0;
        master_drop(0);
        chk("burst_m0_still_owner", grant, GNT_M0);
        tick();
        chk("burst_done", grant, GNT_IDLE);

        // Timeout: strobe never acked.
        s_dat_r = 32'hDEAD_0000;
        master_req(0, 24'h00C000, 1'b0);
        tick();
        chk("to_grant", grant, GNT_M0);
        repeat (254) tick();
        expect_resp(0, 1, 0, 0, 1);
        tick();
        chk("to_s_cyc", s_cyc, 0);
        chk("to_idle", grant, GNT_IDLE);
        master_drop(0);
        tick();

        // Ack on the final stalled cycle wins over the timeout.
        master_req(0, 24'h00D000, 1'b0);
        tick();
        chk("ackwin_grant", grant, GNT_M0);
        repeat (254) tick();
        slave_ack(32'h0255_0255);
        expect_resp(1, 0, 0, 0, 0);
        tick();
        s_ack = 1'b0;
        master_drop(0);
        chk("ackwin_owner", grant, GNT_M0);
        tick();
        chk("ackwin_idle", grant, GNT_IDLE);

        // Reset asserted during an m1 burst.
        master_req(1, 24'h00E000, 1'b1);
        tick();
        chk("rst_burst_grant", grant, GNT_M1);
        slave_ack(32'hE000_0001);
        expect_resp(0, 0, 1, 0, 0);
        tick();
        s_ack = 1'b0;
        tick();
        rst_n = 1'b0;
        slave_ack(32'hE000_0002);
        #1;
        chk("rst_async_grant", grant, GNT_IDLE);
        chk("rst_async_s_cyc", s_cyc, 0);
        master_drop(1);
        tick();
        tick();
        s_ack = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rst_after_idle", grant, GNT_IDLE);
        master_req(1, 24'h00F000, 1'b0);
        tick();
        chk("rst_new_grant", grant, GNT_M1);
        slave_ack(32'hF000_0001);
        expect_resp(0, 0, 1, 0, 0);
        tick();
        s_ack = 1'b0;
        master_drop(1);
        tick();
        chk("rst_new_done", grant, GNT_IDLE);

        tick();
        chk("pending_resp", exp_q.size(), 0);
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_sdr_arbiter.md
WB_SDR_ARBITER -- requirements
Module: wb_sdr_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): AW, 24, Wishbone address width; DW, 32, data width; MAX_HOLD, 16, acks m0 may take while m1 waits; TIMEOUT, 255, cycles of unacked strobe before error.
REQ-002 Ports SHALL be (name, direction, width, meaning): clk, in, 1, sole clock; rst_n, in, 1, asynchronous active-low reset.
REQ-003 m0_cyc, m0_stb, m0_we: in, 1 each; screen DMA master, high priority.
REQ-004 m0_adr, in, AW; m0_sel, in, DW/8; m0_dat_w, in, DW; m0_dat_r, out, DW; m0_ack, out, 1; m0_err, out, 1.
REQ-005 Processor master m1 SHALL have the same port set with the prefix m1_.
REQ-006 Slave side (SDRAM bridge): s_cyc, s_stb, s_we out 1; s_adr out AW; s_sel out DW/8; s_dat_w out DW; s_dat_r in DW; s_ack in 1.
REQ-007 grant, out, 2: one-hot owner, bit0 = m0, bit1 = m1, 00 = idle; timeout_evt, out, 1: one-cycle pulse when a timeout fires.

Function
REQ-008 FSM states SHALL be IDLE, OWN0, OWN1; the state register is the only source of grant.
REQ-009 IDLE: if fair_flag=1 and m1_cyc, go to OWN1 and clear fair_flag; else if m0_cyc, go to OWN0; else if m1_cyc, go to OWN1; else stay.
REQ-010 OWN0/OWN1: s_cyc, s_stb, s_we, s_adr, s_sel and s_dat_w SHALL mirror the owner combinationally; s_dat_r goes to both m*_dat_r; s_ack goes only to the owner's ack.
REQ-011 In IDLE, s_cyc=s_stb=0, and every m*_ack and m*_err SHALL be 0.
REQ-012 The owner SHALL keep the grant while its cyc=1, including bursts; when cyc falls, the next state is IDLE.
REQ-013 hold_cnt, 5 bits and saturating, SHALL count s_ack cycles in OWN0 and clear on entry to OWN0.
REQ-014 Preemption: if in OWN0 with hold_cnt=MAX_HOLD, m1_cyc=1 and s_ack=1 in the same cycle, the next state SHALL be IDLE with fair_flag set; no transfer may be cut mid-strobe.
REQ-015 m1 SHALL never be preempted.
REQ-016 Every ownership change SHALL pass through one IDLE cycle; there is no back-to-back OWN0 to OWN1 handoff.
REQ-017 to_cnt, 8 bits, SHALL count cycles with s_stb=1 and s_ack=0, and clear on s_ack or on leaving ownership.
REQ-018 When to_cnt=TIMEOUT-1 and s_ack=0, the owner's err SHALL pulse for 1 cycle, timeout_evt SHALL pulse, and the next state SHALL be IDLE.
REQ-019 If s_ack and the timeout condition occur in the same cycle, ack SHALL win: no err is raised.
REQ-020 If both m0_cyc and m1_cyc rise in the same IDLE cycle with fair_flag=0, m0 SHALL win.
REQ-021 The grant decision SHALL take 1 cycle, from cyc seen in IDLE to grant asserted on the next edge; there is no added data latency while owned.

Reset
REQ-022 When rst_n=0, asynchronously: state=IDLE, grant=00, fair_flag=0, hold_cnt=0, to_cnt=0, timeout_evt=0, all acks and errs 0, s_cyc=s_stb=0.
REQ-023 If reset is asserted mid-transfer, the transfer SHALL be abandoned with no ack or err issued; after release, arbitration restarts from IDLE.

Structure
REQ-024 The state enum, the grant encoding and the default MAX_HOLD/TIMEOUT constants SHALL live in shared package wb_arb_pkg.
REQ-025 The timeout counter SHALL be sub-module wb_timeout_mon, with inputs clk, rst_n, stb, ack, clr and output expired; all other logic stays in one module.

Verification
REQ-026 Single m1 read: m1_cyc/stb held and s_ack 3 cycles later -> grant=10 one cycle after cyc, m1_ack=1 for exactly 1 cycle, m1_dat_r=s_dat_r, then IDLE.
REQ-027 Simultaneous request: m0_cyc and m1_cyc rise in the same cycle -> grant=01 first; m1 is granted only after m0_cyc falls plus 1 IDLE cycle.
REQ-028 Starvation guard: m0 bursts 40 acks while m1 waits -> release after the 16th ack, then IDLE, then grant=10; m0 regains the bus after m1_cyc falls.
REQ-029 Timeout: m0 strobes and s_ack is never given -> m0_err and timeout_evt pulse at cycle 255, s_cyc=0 the next cycle, state IDLE.
REQ-030 Ack at cycle 255 of a stalled strobe -> m0_ack=1, m0_err=0, timeout_evt=0.
REQ-031 rst_n driven low during an OWN1 burst -> grant=00 and s_cyc=0 immediately, no m1_ack or m1_err; a new m1 request after release is served normally.
